// File: rtl/sim_status_monitor.sv
// Simulation status monitor: watches retire/writeback/AXI-write activity and
// produces a sticky registered verdict, plus a show-ahead console byte FIFO.
module sim_status_monitor #(
  parameter int          RETIRE_CH    = 2,
  parameter int          WB_CH        = 3,
  parameter int          WB_W         = 64,
  parameter int          BUS_BYTES    = 16,
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] CONSOLE_ADDR = 32'h01FF_FFF0,
  parameter logic [63:0] PASS_VAL     = 64'h4_4433_3222,
  parameter logic [63:0] FAIL_VAL     = 64'h23_8234_8720,
  parameter int          WDOG_WIN     = 50000,
  parameter logic [31:0] MAX_CYCLES   = 32'h300_0000,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic [RETIRE_CH-1:0]   retire,
  input  logic [WB_CH-1:0]       wb_vld,
  input  logic [WB_CH*WB_W-1:0]  wb_data,
  input  logic                   bus_wvalid,
  input  logic                   bus_clk_en,
  input  logic [ADDR_W-1:0]      bus_awaddr,
  input  logic [3:0]             bus_awlen,
  input  logic [BUS_BYTES-1:0]   bus_wstrb,
  input  logic [8*BUS_BYTES-1:0] bus_wdata,
  input  logic                   con_pop,
  output logic [7:0]             con_data,
  output logic                   con_empty,
  output logic                   con_ovf,
  output logic                   done,
  output logic                   pass,
  output logic [1:0]             fail_code,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       retire_total
);

  localparam int LANES = BUS_BYTES / 4;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int WIN_W = $clog2(WDOG_WIN);
  localparam int POP_W = $clog2(RETIRE_CH + 1);
  localparam logic [WB_W-1:0] PASS_CMP = WB_W'(PASS_VAL);
  localparam logic [WB_W-1:0] FAIL_CMP = WB_W'(FAIL_VAL);

  typedef enum logic {ST_RUN, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    pass_q, pass_d;
  logic [1:0]              code_q, code_d;
  logic [CNT_W-1:0]        cycle_q, cycle_d, cycle_inc;
  logic [CNT_W-1:0]        retire_q, retire_d, retire_sat;
  logic [CNT_W:0]          retire_sum;
  logic [POP_W-1:0]        retire_pop;
  logic [WIN_W-1:0]        wdog_cnt_q, wdog_cnt_d;
  logic                    wdog_flag_q, wdog_flag_d;
  logic                    wdog_wrap, wdog_hit, timeout_hit, any_retire;
  logic [WB_CH-1:0]        s1_vld_q;
  logic [WB_CH*WB_W-1:0]   s1_data_q;
  logic                    pass_hit, fail_hit;

  logic [7:0]              mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [AW:0]             count_q;
  logic                    ovf_q;
  logic                    lane_hit, beat_ok, push_req, push_ok, pop_ok, full, drop;
  logic [7:0]              lane_byte;

  // Stage-1 writeback register: magic-value compare works on this copy.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      s1_vld_q  <= '0;
      s1_data_q <= '0;
    end else begin
      s1_vld_q  <= wb_vld;
      s1_data_q <= wb_data;
    end
  end

  always_comb begin
    pass_hit   = 1'b0;
    fail_hit   = 1'b0;
    retire_pop = '0;
    for (int k = 0; k < WB_CH; k++) begin
      if (s1_vld_q[k] && (s1_data_q[k*WB_W +: WB_W] == PASS_CMP)) pass_hit = 1'b1;
      if (s1_vld_q[k] && (s1_data_q[k*WB_W +: WB_W] == FAIL_CMP)) fail_hit = 1'b1;
    end
    for (int k = 0; k < RETIRE_CH; k++) retire_pop = retire_pop + POP_W'(retire[k]);
  end

  assign retire_sum  = {1'b0, retire_q} + (CNT_W+1)'(retire_pop);
  assign retire_sat  = retire_sum[CNT_W] ? '1 : retire_sum[CNT_W-1:0];
  assign cycle_inc   = (&cycle_q) ? cycle_q : cycle_q + CNT_W'(1);
  assign any_retire  = |retire;
  assign wdog_wrap   = (wdog_cnt_q == WIN_W'(WDOG_WIN - 1));
  assign wdog_hit    = wdog_wrap && !(wdog_flag_q || any_retire);
  assign timeout_hit = (cycle_inc == CNT_W'(MAX_CYCLES));

  // Verdict priority: pass > fail value > watchdog > timeout.
  always_comb begin
    state_d     = state_q;
    pass_d      = pass_q;
    code_d      = code_q;
    cycle_d     = cycle_q;
    retire_d    = retire_q;
    wdog_cnt_d  = wdog_cnt_q;
    wdog_flag_d = wdog_flag_q;
    case (state_q)
      ST_RUN: begin
        cycle_d  = cycle_inc;
        retire_d = retire_sat;
        if (wdog_wrap) begin
          wdog_cnt_d  = '0;
          wdog_flag_d = 1'b0;
        end else begin
          wdog_cnt_d  = wdog_cnt_q + WIN_W'(1);
          wdog_flag_d = wdog_flag_q | any_retire;
        end
        if (pass_hit) begin
          state_d = ST_DONE;
          pass_d  = 1'b1;
          code_d  = 2'b00;
        end else if (fail_hit) begin
          state_d = ST_DONE;
          code_d  = 2'b01;
        end else if (wdog_hit) begin
          state_d = ST_DONE;
          code_d  = 2'b10;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          code_d  = 2'b11;
        end
      end
      ST_DONE: ;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_RUN;
      pass_q      <= 1'b0;
      code_q      <= 2'b00;
      cycle_q     <= '0;
      retire_q    <= '0;
      wdog_cnt_q  <= '0;
      wdog_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pass_q      <= pass_d;
      code_q      <= code_d;
      cycle_q     <= cycle_d;
      retire_q    <= retire_d;
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_flag_q <= wdog_flag_d;
    end
  end

  // A console beat must strobe exactly one aligned 32-bit lane.
  always_comb begin
    lane_hit  = 1'b0;
    lane_byte = 8'h00;
    for (int k = 0; k < LANES; k++) begin
      if (bus_wstrb == (BUS_BYTES'(4'hF) << (4 * k))) begin
        lane_hit  = 1'b1;
        lane_byte = bus_wdata[32*k +: 8];
      end
    end
  end

  assign beat_ok  = bus_wvalid && bus_clk_en && (bus_awlen == 4'd0) &&
                    (bus_awaddr == ADDR_W'(CONSOLE_ADDR));
  assign push_req = beat_ok && lane_hit;
  assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop_ok   = con_pop && (count_q != '0);
  assign push_ok  = push_req && (!full || pop_ok);
  assign drop     = push_req && full && !pop_ok;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= lane_byte;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      ovf_q <= ovf_q | drop;
    end
  end

  assign con_empty    = (count_q == '0);
  assign con_data     = con_empty ? 8'h00 : mem[rd_ptr_q];
  assign con_ovf      = ovf_q;
  assign done         = (state_q == ST_DONE);
  assign pass         = pass_q;
  assign fail_code    = code_q;
  assign cycle_cnt    = cycle_q;
  assign retire_total = retire_q;

endmodule

// File: tb/tb_sim_status_monitor.sv
// Directed bench for sim_status_monitor with small watchdog, timeout and FIFO
// parameters; expected values are hand-computed constants.
module tb_sim_status_monitor;

  localparam logic [63:0]  PASS_V = 64'h4_4433_3222;
  localparam logic [63:0]  FAIL_V = 64'h23_8234_8720;
  localparam logic [31:0]  CON_A  = 32'h01FF_FFF0;

  logic         clk;
  logic         rst_b;
  logic [1:0]   retire;
  logic [2:0]   wb_vld;
  logic [191:0] wb_data;
  logic         bus_wvalid, bus_clk_en;
  logic [31:0]  bus_awaddr;
  logic [3:0]   bus_awlen;
  logic [15:0]  bus_wstrb;
  logic [127:0] bus_wdata;
  logic         con_pop;
  logic [7:0]   con_data;
  logic         con_empty, con_ovf, done, pass;
  logic [1:0]   fail_code;
  logic [31:0]  cycle_cnt, retire_total;

  int checks = 0;
  int passes = 0;

  sim_status_monitor #(
    .RETIRE_CH(2), .WB_CH(3), .WB_W(64), .BUS_BYTES(16), .ADDR_W(32),
    .CONSOLE_ADDR(CON_A), .PASS_VAL(PASS_V), .FAIL_VAL(FAIL_V),
    .WDOG_WIN(8), .MAX_CYCLES(32'd100), .FIFO_DEPTH(4), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_b(rst_b), .retire(retire), .wb_vld(wb_vld), .wb_data(wb_data),
    .bus_wvalid(bus_wvalid), .bus_clk_en(bus_clk_en), .bus_awaddr(bus_awaddr),
    .bus_awlen(bus_awlen), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .con_pop(con_pop), .con_data(con_data), .con_empty(con_empty), .con_ovf(con_ovf),
    .done(done), .pass(pass), .fail_code(fail_code), .cycle_cnt(cycle_cnt),
    .retire_total(retire_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " done"}, 64'(done), 64'd0);
    checkOutput({tag, " pass"}, 64'(pass), 64'd0);
    checkOutput({tag, " code"}, 64'(fail_code), 64'd0);
    checkOutput({tag, " cycle"}, 64'(cycle_cnt), 64'd0);
    checkOutput({tag, " retire"}, 64'(retire_total), 64'd0);
    checkOutput({tag, " empty"}, 64'(con_empty), 64'd1);
    checkOutput({tag, " data"}, 64'(con_data), 64'd0);
    checkOutput({tag, " ovf"}, 64'(con_ovf), 64'd0);
  endtask

  // Leaves the bench at a negedge with reset released; next posedge is edge 1.
  task automatic doReset();
    rst_b = 1'b0; retire = '0; wb_vld = '0; wb_data = '0;
    bus_wvalid = 1'b0; bus_clk_en = 1'b0; bus_awaddr = '0; bus_awlen = '0;
    bus_wstrb = '0; bus_wdata = '0; con_pop = 1'b0;
    step(2);
    rst_b = 1'b1;
  endtask

  function automatic logic [127:0] mkData(input int lane, input logic [7:0] b);
    logic [127:0] d;
    d = {16{8'hA5}};
    d[32*lane +: 8] = b;
    return d;
  endfunction

  // One bus cycle: optional write beat and optional pop, then back to idle.
  task automatic applyStimulus(input logic wv, input logic en, input logic [31:0] addr,
                               input logic [3:0] len, input logic [15:0] strb,
                               input logic [127:0] data, input logic pop);
    bus_wvalid = wv; bus_clk_en = en; bus_awaddr = addr; bus_awlen = len;
    bus_wstrb = strb; bus_wdata = data; con_pop = pop;
    step(1);
    bus_wvalid = 1'b0; con_pop = 1'b0;
  endtask

  initial begin
    doReset();
    rst_b = 1'b0;
    checkReset("reset");
    rst_b = 1'b1;

    // Pass value on channel 2, two-edge latency, then frozen counters.
    doReset();
    retire = 2'b01;
    wb_vld = 3'b100; wb_data[128 +: 64] = PASS_V;
    step(1);
    wb_vld = '0;
    checkOutput("pass latency", 64'(done), 64'd0);
    step(1);
    checkOutput("pass done", 64'(done), 64'd1);
    checkOutput("pass pass", 64'(pass), 64'd1);
    checkOutput("pass code", 64'(fail_code), 64'd0);
    checkOutput("pass cycle", 64'(cycle_cnt), 64'd2);
    step(3);
    checkOutput("pass cycle frozen", 64'(cycle_cnt), 64'd2);
    checkOutput("pass retire frozen", 64'(retire_total), 64'd2);

    // Invalid channels ignored, then pass wins over fail in one cycle.
    doReset();
    retire = 2'b01;
    wb_data[0 +: 64] = FAIL_V; wb_data[64 +: 64] = PASS_V;
    step(3);
    checkOutput("invalid ch ignored", 64'(done), 64'd0);
    wb_vld = 3'b011;
    step(1);
    wb_vld = '0;
    step(1);
    checkOutput("prio pass", 64'(pass), 64'd1);
    checkOutput("prio code", 64'(fail_code), 64'd0);

    // Fail value alone, verdict then stays put.
    doReset();
    retire = 2'b01;
    wb_vld = 3'b001; wb_data[0 +: 64] = FAIL_V;
    step(1);
    wb_vld = '0;
    step(1);
    checkOutput("fail done", 64'(done), 64'd1);
    checkOutput("fail pass", 64'(pass), 64'd0);
    checkOutput("fail code", 64'(fail_code), 64'd1);
    wb_vld = 3'b010; wb_data[64 +: 64] = PASS_V;
    step(2);
    wb_vld = '0;
    checkOutput("fail sticky pass", 64'(pass), 64'd0);
    checkOutput("fail sticky code", 64'(fail_code), 64'd1);

    // Watchdog with no retires fires on edge 8.
    doReset();
    step(7);
    checkOutput("wdog early", 64'(done), 64'd0);
    step(1);
    checkOutput("wdog done", 64'(done), 64'd1);
    checkOutput("wdog code", 64'(fail_code), 64'd2);
    checkOutput("wdog cycle", 64'(cycle_cnt), 64'd8);

    // One retire sampled on edge 5 pushes the verdict to edge 16.
    doReset();
    step(4);
    retire = 2'b01;
    step(1);
    retire = 2'b00;
    step(10);
    checkOutput("wdog delayed early", 64'(done), 64'd0);
    step(1);
    checkOutput("wdog delayed done", 64'(done), 64'd1);
    checkOutput("wdog delayed code", 64'(fail_code), 64'd2);
    checkOutput("wdog delayed retire", 64'(retire_total), 64'd1);

    // Retire popcount: 10 x 2 + 3 x 1.
    doReset();
    retire = 2'b11;
    step(10);
    retire = 2'b01;
    step(3);
    checkOutput("retire total", 64'(retire_total), 64'd23);
    checkOutput("retire cycle", 64'(cycle_cnt), 64'd13);
    checkOutput("retire no verdict", 64'(done), 64'd0);

    // Console lane selection and rejected beats.
    doReset();
    retire = 2'b01;
    applyStimulus(1'b1, 1'b1, CON_A, 4'd0, 16'h000F, mkData(0, 8'h4F), 1'b0);
    checkOutput("con first empty", 64'(con_empty), 64'd0);
    checkOutput("con first head", 64'(con_data), 64'h4F);
    applyStimulus(1'b1, 1'b1, CON_A, 4'd0, 16'h00F0, mkData(1, 8'h4B), 1'b0);
    applyStimulus(1'b1, 1'b1, CON_A, 4'd0, 16'hF000, mkData(3, 8'h0A), 1'b0);
    applyStimulus(1'b1, 1'b1, CON_A, 4'd0, 16'h00FF, mkData(0, 8'h58), 1'b0);
    applyStimulus(1'b1, 1'b1, CON_A, 4'd1, 16'h000F, mkData(0, 8'h59), 1'b0);
    applyStimulus(1'b1, 1'b0, CON_A, 4'd0, 16'h000F, mkData(0, 8'h5A), 1'b0);
    applyStimulus(1'b1, 1'b1, CON_A + 32'd4, 4'd0, 16'h000F, mkData(0, 8'h5B), 1'b0);
    checkOutput("con head O", 64'(con_data), 64'h4F);
    applyStimulus(1'b0, 1'b0, '0, 4'd0, '0, '0, 1'b1);
    checkOutput("con head K", 64'(con_data), 64'h4B);
    applyStimulus(1'b0, 1'b0, '0, 4'd0, '0, '0, 1'b1);
    checkOutput("con head nl", 64'(con_data), 64'h0A);
    applyStimulus(1'b0, 1'b0, '0, 4'd0, '0, '0, 1'b1);
    checkOutput("con drained", 64'(con_empty), 64'd1);
    applyStimulus(1'b0, 1'b0, '0, 4'd0, '0, '0, 1'b1);
    checkOutput("con pop empty", 64'(con_empty), 64'd1);
    applyStimulus(1'b1, 1'b1, CON_A, 4'd0, 16'h0F00, mkData(2, 8'h5A), 1'b0);
    checkOutput("con after empty pop", 64'(con_data), 64'h5A);
    checkOutput("con no ovf", 64'(con_ovf), 64'd0);

    // Overflow on the fifth push, then simultaneous push/pop while full.
    doReset();
    retire = 2'b01;
    for (int i = 1; i <= 4; i++)
      applyStimulus(1'b1, 1'b1, CON_A, 4'd0, 16'h000F, mkData(0, 8'(i)), 1'b0);
    checkOutput("ovf before", 64'(con_ovf), 64'd0);
    applyStimulus(1'b1, 1'b1, CON_A, 4'd0, 16'h000F, mkData(0, 8'd5), 1'b0);
    checkOutput("ovf set", 64'(con_ovf), 64'd1);
    checkOutput("ovf head", 64'(con_data), 64'd1);
    applyStimulus(1'b1, 1'b1, CON_A, 4'd0, 16'h000F, mkData(0, 8'd6), 1'b1);
    checkOutput("full push+pop head", 64'(con_data), 64'd2);
    applyStimulus(1'b0, 1'b0, '0, 4'd0, '0, '0, 1'b1);
    checkOutput("ovf read 3", 64'(con_data), 64'd3);
    applyStimulus(1'b0, 1'b0, '0, 4'd0, '0, '0, 1'b1);
    checkOutput("ovf read 4", 64'(con_data), 64'd4);
    applyStimulus(1'b0, 1'b0, '0, 4'd0, '0, '0, 1'b1);
    checkOutput("ovf read 6", 64'(con_data), 64'd6);
    applyStimulus(1'b0, 1'b0, '0, 4'd0, '0, '0, 1'b1);
    checkOutput("ovf drained", 64'(con_empty), 64'd1);
    checkOutput("ovf sticky", 64'(con_ovf), 64'd1);

    // Timeout at MAX_CYCLES, console still live in DONE, async reset.
    doReset();
    retire = 2'b01;
    step(99);
    checkOutput("timeout early", 64'(done), 64'd0);
    checkOutput("timeout early cycle", 64'(cycle_cnt), 64'd99);
    step(1);
    checkOutput("timeout done", 64'(done), 64'd1);
    checkOutput("timeout code", 64'(fail_code), 64'd3);
    checkOutput("timeout pass", 64'(pass), 64'd0);
    checkOutput("timeout cycle", 64'(cycle_cnt), 64'd100);
    checkOutput("timeout retire", 64'(retire_total), 64'd100);
    applyStimulus(1'b1, 1'b1, CON_A, 4'd0, 16'h000F, mkData(0, 8'h51), 1'b0);
    checkOutput("done console head", 64'(con_data), 64'h51);
    checkOutput("done cycle frozen", 64'(cycle_cnt), 64'd100);
    #2 rst_b = 1'b0;
    #1 checkReset("async reset");
    step(1);
    rst_b = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sim_status_monitor.md
# sim_status_monitor

Parametrised, synthesizable simulation status monitor that sits beside the SoC in the C908 test environment. It watches retire pulses, writeback values and the AXI write channel, and produces one registered verdict: pass, fail-value, watchdog or timeout. It also captures console bytes written to a magic address into a show-ahead FIFO. It generalises the fixed two-retire / three-writeback / 128-bit checks to N channels and B-byte buses, and adds retire-count statistics and overflow reporting.

## Interface
Parameters:
- RETIRE_CH, 2, number of retire pulse inputs
- WB_CH, 3, number of writeback channels compared against the magic values
- WB_W, 64, writeback data width
- BUS_BYTES, 16, write data bus width in bytes; must be a multiple of 4
- ADDR_W, 32, AXI address width
- CONSOLE_ADDR, 32'h01FF_FFF0, console write address
- PASS_VAL, 64'h4_4433_3222, pass magic value
- FAIL_VAL, 64'h23_8234_8720, fail magic value
- WDOG_WIN, 50000, watchdog window length in cycles; must be ≥ 2
- MAX_CYCLES, 32'h300_0000, timeout in cycles
- FIFO_DEPTH, 16, console FIFO depth; must be a power of 2
- CNT_W, 32, statistics counter width

Ports:
- clk  in  1  clock
- rst_b  in  1  asynchronous, active-low reset
- retire  in  RETIRE_CH  one retire pulse per channel per cycle
- wb_vld  in  WB_CH  writeback valid per channel
- wb_data  in  WB_CH*WB_W  writeback data; channel k occupies [k*WB_W +: WB_W]
- bus_wvalid  in  1  write data valid
- bus_clk_en  in  1  bus clock enable; a beat counts only when this is 1
- bus_awaddr  in  ADDR_W  latched write address
- bus_awlen  in  4  burst length
- bus_wstrb  in  BUS_BYTES  byte strobes
- bus_wdata  in  8*BUS_BYTES  write data
- con_pop  in  1  pop the console FIFO head
- con_data  out  8  FIFO head byte; show-ahead
- con_empty  out  1  FIFO empty
- con_ovf  out  1  sticky flag: a byte was dropped
- done  out  1  verdict reached; sticky
- pass  out  1  valid while done=1
- fail_code  out  2  00 pass/none, 01 fail value, 10 watchdog, 11 timeout
- cycle_cnt  out  CNT_W  cycles since reset; saturating
- retire_total  out  CNT_W  instructions retired; saturating

## Operation
- Two-state FSM, RUN → DONE. DONE is left only by reset.
- **cycle_cnt**
  - Increments every cycle in RUN; frozen in DONE.
  - Reaching MAX_CYCLES in RUN: DONE with code 11.
- **retire_total**
  - Adds popcount(retire) each RUN cycle; saturates at all-ones.
  - All channels are counted, not just one per cycle.
- **Watchdog**
  - Window counter runs 0 to WDOG_WIN-1 and wraps.
  - Window retire flag is set by any retire bit.
  - At wrap: if the flag was clear for the whole window, including the wrap cycle, go to DONE with code 10. Otherwise clear the flag.
- **Magic-value check**
  - wb_vld and wb_data are registered (stage 1).
  - Any valid stage-1 channel equal to PASS_VAL → pass.
  - Any valid stage-1 channel equal to FAIL_VAL → code 01.
  - Comparison uses the low WB_W bits of each value, zero-extended.
- **Simultaneous events in one cycle:** priority is pass > fail value > watchdog > timeout.
- **Console capture** (active in RUN and DONE, so late prints still drain)
  - Qualified beat: bus_wvalid & bus_clk_en & awlen==0 & awaddr==CONSOLE_ADDR.
  - Byte selection: wstrb must be exactly 4'hF shifted to one lane k; the byte taken is wdata[32k +: 8].
  - Any other strobe pattern is ignored.
- **FIFO**
  - Push when full with no pop in the same cycle: byte dropped, con_ovf set.
  - Push and pop together when full: both happen.
  - Pop when empty: ignored.
- **Reset values:** all counters 0, FIFO empty, con_ovf=0, done=0, pass=0, fail_code=00, con_data=0, state RUN.
- Reset asserted mid-run clears everything immediately (asynchronous).

## Timing
- Writeback at edge t (sampled) → done/pass/fail_code registered at edge t+1; visible in the following cycle. Latency is 2 cycles from drive to visible.
- Watchdog and timeout verdicts are registered on the detecting edge.
- Console push at edge t: con_empty=0 and con_data valid after t.
- Pop at edge t: the next head is presented after t.
- done/pass/fail_code never change once done=1.

## Test plan
- **Pass value:** after reset, drive wb_vld[2]=1 with data 64'h444333222 for one cycle → two edges later done=1, pass=1, fail_code=00; cycle_cnt frozen.
- **Priority:** in the same cycle drive channel 0 = FAIL_VAL and channel 1 = PASS_VAL → pass=1. Channel 0 alone = FAIL_VAL → pass=0, fail_code=01.
- **Watchdog:** WDOG_WIN=8, no retire pulses → done at the 8th cycle with code 10. A single retire in cycle 5 delays done to the end of the next window.
- **Retire count:** retire=2'b11 for 10 cycles plus 2'b01 for 3 cycles → retire_total=23.
- **Console:** BUS_BYTES=16; qualified beats with wstrb 16'h000F, 16'h00F0 and 16'hF000 carrying 'O','K','\n' → pops return 'O','K','\n'. wstrb 16'h00FF → no push. awlen=1 → no push.
- **Overflow and reset:**
  - FIFO_DEPTH=4, push 5 bytes → con_ovf=1, 4 bytes readable.
  - Push and pop together when full → count unchanged.
  - Assert rst_b mid-test → all outputs back to their reset values.
